// File: rtl/cabac_bae_bits_ctrl_if.sv
// cabac_bae_bits_ctrl_if: beat input and byte output handshake bundle of the BAE bit-output controller
interface cabac_bae_bits_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] bits_num;
   logic [4:0] bits;
   logic       carry;
   logic       flush;
   logic       out_valid;
   logic [7:0] out_byte;
   logic       out_ready;
   logic       done;
   logic       err;
   modport master (output in_valid, bits_num, bits, carry, flush, out_ready,
                   input  in_ready, out_valid, out_byte, done, err);
   modport slave  (input  in_valid, bits_num, bits, carry, flush, out_ready,
                   output in_ready, out_valid, out_byte, done, err);
endinterface

// File: rtl/cabac_bae_bits_ctrl.sv
// cabac_bae_bits_ctrl: resolves BAE carries into buffered byte + 0xFF run and emits packed bytes
// Optional macro CABAC_BAE_BITS_ERR_EN enables the sticky protocol error flag.
module cabac_bae_bits_ctrl #(
   parameter int FF_CNT_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   cabac_bae_bits_ctrl_if.slave s
);
   typedef enum logic [2:0] {IDLE, EMIT_BUF, EMIT_RUN, LOAD, FLUSH_LAST} state_t;
   state_t              state;
   logic [6:0]          partial, np;
   logic [2:0]          part_cnt, n;
   logic [7:0]          buf_byte, nxt_byte, mask, cp, pad, cb;
   logic [4:0]          bmask;
   logic [15:0]         cat;
   logic [3:0]          tot, sh;
   logic [FF_CNT_W-1:0] ff_cnt;
   logic                buf_vld, run_carry, flushing, fdrain, has_last;
   logic                ovf, cmp, rc_n, take, fstep, run_end, fin, ff_full;
   assign s.in_ready = (state == IDLE) && !flushing;
   // Beat datapath: carry into the partial bits, append new bits, extract a completed byte
   always_comb begin
      n = (s.bits_num > 3'd5) ? 3'd5 : s.bits_num;
      mask = (8'd1 << part_cnt) - 8'd1;
      ovf = s.carry && (({1'b0, partial} & mask) == mask);
      cp = s.carry ? (({1'b0, partial} + 8'd1) & mask) : {1'b0, partial};
      bmask = 5'((6'd1 << n) - 6'd1);
      cat = ({8'd0, cp} << n) | {11'd0, s.bits & bmask};
      tot = {1'b0, part_cnt} + {1'b0, n};
      cmp = tot >= 4'd8;
      sh = cmp ? tot - 4'd8 : 4'd0;
      cb = 8'(cat >> sh);
      np = cmp ? 7'(cat & ((16'd1 << sh) - 16'd1)) : cat[6:0];
      rc_n = run_carry | ovf;
      pad = {1'b0, partial} << (4'd8 - {1'b0, part_cnt});
      take = (state == IDLE) && !flushing && s.in_valid;
      fstep = (state == IDLE) && (flushing || (s.flush && !s.in_valid));
      ff_full = &ff_cnt;
      run_end = (state == EMIT_BUF) ? (ff_cnt == '0) : (ff_cnt == FF_CNT_W'(1));
      fin = (fstep && part_cnt == 3'd0 && !buf_vld) ||
            (s.out_ready && ((state == FLUSH_LAST) ||
             ((state == EMIT_BUF || state == EMIT_RUN) && run_end && fdrain && !has_last)));
   end
   // Control FSM: absorb beats, emit buffered byte and run, reload or finish a flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         partial     <= '0;
         part_cnt    <= '0;
         buf_byte    <= '0;
         nxt_byte    <= '0;
         buf_vld     <= 1'b0;
         ff_cnt      <= '0;
         run_carry   <= 1'b0;
         flushing    <= 1'b0;
         fdrain      <= 1'b0;
         has_last    <= 1'b0;
         s.out_valid <= 1'b0;
         s.out_byte  <= '0;
         s.done      <= 1'b0;
      end else begin
         s.done <= fin;
         case (state)
            IDLE: begin
               if (fstep) begin
                  flushing    <= 1'b1;
                  fdrain      <= 1'b1;
                  partial     <= '0;
                  part_cnt    <= '0;
                  has_last    <= buf_vld && part_cnt != 3'd0;
                  nxt_byte    <= pad;
                  if (!buf_vld) buf_byte <= pad;
                  state       <= EMIT_BUF;
                  s.out_valid <= 1'b1;
                  s.out_byte  <= buf_vld ? buf_byte + {7'd0, run_carry} : pad;
               end else if (take) begin
                  partial   <= np;
                  part_cnt  <= cmp ? sh[2:0] : tot[2:0];
                  run_carry <= rc_n;
                  flushing  <= s.flush;
                  if (cmp && !buf_vld) begin
                     buf_byte <= cb;
                     buf_vld  <= 1'b1;
                  end else if (cmp && cb == 8'hFF && !rc_n) begin
                     ff_cnt <= ff_full ? ff_cnt : ff_cnt + FF_CNT_W'(1);
                  end else if (cmp) begin
                     nxt_byte    <= cb;
                     state       <= EMIT_BUF;
                     s.out_valid <= 1'b1;
                     s.out_byte  <= buf_byte + {7'd0, rc_n};
                  end
               end
            end
            EMIT_BUF, EMIT_RUN: begin
               if (s.out_ready) begin
                  if (state == EMIT_RUN) ff_cnt <= ff_cnt - FF_CNT_W'(1);
                  if (!run_end) begin
                     state      <= EMIT_RUN;
                     s.out_byte <= run_carry ? 8'h00 : 8'hFF;
                  end else if (!fdrain) begin
                     state       <= LOAD;
                     s.out_valid <= 1'b0;
                  end else begin
                     state      <= FLUSH_LAST;
                     s.out_byte <= nxt_byte;
                  end
               end
            end
            LOAD: begin
               buf_byte  <= nxt_byte;
               run_carry <= 1'b0;
               state     <= IDLE;
            end
            default: ;
         endcase
         if (fin) begin
            state       <= IDLE;
            partial     <= '0;
            part_cnt    <= '0;
            buf_byte    <= '0;
            buf_vld     <= 1'b0;
            ff_cnt      <= '0;
            run_carry   <= 1'b0;
            flushing    <= 1'b0;
            fdrain      <= 1'b0;
            has_last    <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_byte  <= '0;
         end
      end
   end
`ifdef CABAC_BAE_BITS_ERR_EN
   // Sticky error on double/orphan carry overflow, oversized beat or run counter saturation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s.err <= 1'b0;
      else if (take && (s.bits_num > 3'd5 || (ovf && (run_carry || !buf_vld)) ||
                        (cmp && buf_vld && cb == 8'hFF && !rc_n && ff_full))) s.err <= 1'b1;
   end
`else
   assign s.err = 1'b0;
`endif
endmodule

// File: tb/tb_cabac_bae_bits_ctrl.sv
// tb_cabac_bae_bits_ctrl: directed scoreboard bench for the BAE bit-output controller
module tb_cabac_bae_bits_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         hs_q[$];
`ifdef CABAC_BAE_BITS_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif
   cabac_bae_bits_ctrl_if bif();
   cabac_bae_bits_ctrl #(.FF_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .s(bif));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask
   // Scoreboard: every accepted byte is compared against the oldest expected byte
   always @(negedge clk) begin : mon
      logic [7:0] e;
      if (rst_n && bif.out_valid && bif.out_ready) begin
         if (exp_q.size() != 0) e = exp_q.pop_front();
         else e = 8'hxx;
         chk("out_byte", {24'd0, bif.out_byte}, {24'd0, e});
         hs_q.push_back(cyc);
      end
   end
   task automatic beat(input logic [2:0] n, input logic [4:0] b, input logic c);
      int k = 0;
      while (!bif.in_ready && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("beat_ready", {31'd0, bif.in_ready}, 32'd1);
      bif.in_valid = 1'b1;
      bif.bits_num = n;
      bif.bits = b;
      bif.carry = c;
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
      bif.carry = 1'b0;
   endtask
   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || bif.out_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain", exp_q.size(), 0);
   endtask
   task automatic wait_valid();
      int k = 0;
      while (!bif.out_valid && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("out_valid_seen", {31'd0, bif.out_valid}, 32'd1);
   endtask
   task automatic ff_byte();
      beat(5, 5'b11111, 1'b0);
      beat(3, 5'b00111, 1'b0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int k;
      int span;
      bif.in_valid = 1'b0;
      bif.bits_num = '0;
      bif.bits = '0;
      bif.carry = 1'b0;
      bif.flush = 1'b0;
      bif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
      chk("rst_out_byte", {24'd0, bif.out_byte}, 32'd0);
      chk("rst_done", {31'd0, bif.done}, 32'd0);
      chk("rst_err", {31'd0, bif.err}, 32'd0);
      rst_n = 1'b1;
      beat(5, 5'b10110, 1'b0);
      beat(3, 5'b00101, 1'b0);
      repeat (3) @(negedge clk);
      chk("first_byte_buffered", {31'd0, bif.out_valid}, 32'd0);
      exp_q.push_back(8'hB5);
      beat(5, 5'b00111, 1'b0);
      beat(3, 5'b00100, 1'b0);
      drain();
      beat(3, 5'b00101, 1'b0);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hA0);
      chk("flush_ready", {31'd0, bif.in_ready}, 32'd1);
      @(posedge clk);
      #1 bif.flush = 1'b1;
      @(posedge clk);
      #1 bif.flush = 1'b0;
      k = 0;
      while (!bif.done && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("flush_done", {31'd0, bif.done}, 32'd1);
      chk("flush_bytes_before_done", exp_q.size(), 0);
      @(negedge clk);
      chk("flush_done_pulse", {31'd0, bif.done}, 32'd0);
      chk("flush_cleared_ready", {31'd0, bif.in_ready}, 32'd1);
      chk("flush_cleared_valid", {31'd0, bif.out_valid}, 32'd0);
      hs_q.delete();
      beat(5, 5'b00010, 1'b0);
      beat(3, 5'b00000, 1'b0);
      ff_byte();
      ff_byte();
      exp_q.push_back(8'h10);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      beat(5, 5'b00100, 1'b0);
      beat(3, 5'b00000, 1'b0);
      drain();
      chk("run_burst_len", hs_q.size(), 3);
      span = (hs_q.size() == 3) ? hs_q[2] - hs_q[0] : -1;
      chk("run_back_to_back", span, 2);
      exp_q.push_back(8'h20);
      beat(5, 5'b00010, 1'b0);
      beat(3, 5'b00010, 1'b0);
      ff_byte();
      ff_byte();
      beat(3, 5'b00111, 1'b0);
      exp_q.push_back(8'h13);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      beat(0, 5'b00000, 1'b1);
      beat(5, 5'b00000, 1'b0);
      drain();
      ff_byte();
      ff_byte();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      bif.out_ready = 1'b0;
      beat(5, 5'b01010, 1'b0);
      beat(3, 5'b00101, 1'b0);
      wait_valid();
      chk("stall_buf_byte", {24'd0, bif.out_byte}, 32'h00);
      @(posedge clk);
      #1 bif.out_ready = 1'b1;
      @(posedge clk);
      #1 bif.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, bif.out_valid}, 32'd1);
         chk("stall_byte", {24'd0, bif.out_byte}, 32'hFF);
         chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
      end
      bif.out_ready = 1'b1;
      drain();
      beat(0, 5'b00000, 1'b1);
      @(negedge clk);
      chk("err_single_carry", {31'd0, bif.err}, 32'd0);
      beat(0, 5'b00000, 1'b1);
      @(negedge clk);
      chk("err_double_carry", {31'd0, bif.err}, {31'd0, ERR_EXP});
      repeat (3) @(negedge clk);
      chk("err_sticky", {31'd0, bif.err}, {31'd0, ERR_EXP});
      bif.out_ready = 1'b0;
      beat(5, 5'b00000, 1'b0);
      beat(3, 5'b00000, 1'b0);
      wait_valid();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset_valid", {31'd0, bif.out_valid}, 32'd0);
      chk("mid_reset_in_ready", {31'd0, bif.in_ready}, 32'd1);
      chk("mid_reset_err", {31'd0, bif.err}, 32'd0);
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 bif.flush = 1'b1;
      @(negedge clk);
      chk("empty_flush_not_yet", {31'd0, bif.done}, 32'd0);
      @(posedge clk);
      #1 bif.flush = 1'b0;
      @(negedge clk);
      chk("empty_flush_done", {31'd0, bif.done}, 32'd1);
      chk("empty_flush_no_byte", {31'd0, bif.out_valid}, 32'd0);
      @(negedge clk);
      chk("empty_flush_pulse", {31'd0, bif.done}, 32'd0);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
